// File: rtl/icache_valid_array_if.sv
// Request/response bundle for the instruction-cache valid-bit array:
// read port, masked write port and the bulk-invalidate sweep controls.
interface icache_valid_array_if #(
  parameter int WAYS           = 2,
  parameter int SET_ADDR_WIDTH = 6,
  parameter int CHUNK_BITS     = 3
);
  localparam int CW = SET_ADDR_WIDTH - CHUNK_BITS;
  // Chunk index needs at least one bit even when a single chunk spans the array.
  localparam int PW = (CW > 0) ? CW : 1;

  logic                      rd_en;
  logic [SET_ADDR_WIDTH-1:0] rd_addr;
  logic [WAYS-1:0]           rd_data;
  logic                      wr_en;
  logic [SET_ADDR_WIDTH-1:0] wr_addr;
  logic [WAYS-1:0]           wr_way_mask;
  logic                      wr_value;
  logic                      wr_ready;
  logic                      inv_start;
  logic                      inv_all;
  logic [PW-1:0]             inv_base;
  logic [PW-1:0]             inv_len;
  logic                      inv_busy;
  logic                      inv_done;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_way_mask, wr_value,
           inv_start, inv_all, inv_base, inv_len,
    input  rd_data, wr_ready, inv_busy, inv_done
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_way_mask, wr_value,
           inv_start, inv_all, inv_base, inv_len,
    output rd_data, wr_ready, inv_busy, inv_done
  );
endinterface

// File: rtl/icache_valid_array.sv
// Flop-based valid-bit array with registered read, masked write and a
// chunked bulk-invalidate sweep engine (IDLE -> SWEEP -> DONE).
module icache_valid_array #(
  parameter int WAYS           = 2,
  parameter int SET_ADDR_WIDTH = 6,
  parameter int CHUNK_BITS     = 3
) (
  input logic                 clock,
  input logic                 reset_n,
  icache_valid_array_if.slave bus
);
  localparam int SETS   = 1 << SET_ADDR_WIDTH;
  localparam int CW     = SET_ADDR_WIDTH - CHUNK_BITS;
  localparam int PW     = (CW > 0) ? CW : 1;
  localparam int CHUNKS = 1 << CW;
  // All-ones for CW > 0, zero for a single chunk: doubles as the wrap mask.
  localparam logic [PW-1:0] LAST_CHUNK = PW'(CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] remain;
  logic          busy_q;
  logic          done_q;
  logic [WAYS-1:0] rd_q;
  logic [WAYS-1:0] valid_q [SETS];
  logic            wr_fire;

  assign wr_fire      = bus.wr_en && !busy_q;
  assign bus.wr_ready = !busy_q;
  assign bus.inv_busy = busy_q;
  assign bus.inv_done = done_q;
  assign bus.rd_data  = rd_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      ptr    <= '0;
      remain <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.inv_start) begin
            state  <= SWEEP;
            busy_q <= 1'b1;
            ptr    <= bus.inv_all ? '0 : (bus.inv_base & LAST_CHUNK);
            remain <= bus.inv_all ? LAST_CHUNK : (bus.inv_len & LAST_CHUNK);
          end
        end
        SWEEP: begin
          ptr <= (ptr == LAST_CHUNK) ? '0 : ptr + 1'b1;
          if (remain == '0) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            remain <= remain - 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the array is plain flops, so clearing it in the async reset branch
  // is legal; a RAM macro could not be reset this way.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else begin
      for (int s = 0; s < SETS; s++) begin
        if (state == SWEEP &&
            (SET_ADDR_WIDTH'(s) >> CHUNK_BITS) == SET_ADDR_WIDTH'(ptr)) begin
          valid_q[s] <= '0;
        end else if (wr_fire && bus.wr_addr == SET_ADDR_WIDTH'(s)) begin
          valid_q[s] <= (valid_q[s] & ~bus.wr_way_mask) |
                        (bus.wr_way_mask & {WAYS{bus.wr_value}});
        end
      end
    end
  end

  // NOTE: non-blocking assignment means rd_q samples valid_q before this
  // edge's write or clear lands, which is exactly read-before-write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= '0;
    end else if (bus.rd_en) begin
      rd_q <= valid_q[bus.rd_addr];
    end
  end
endmodule

// File: tb/tb_icache_valid_array.sv
// Directed bench for icache_valid_array: single-cycle vector table followed
// by hand-written sweep sequences (full, ranged/wrapping, repeated start, reset abort).
module tb_icache_valid_array;
  localparam int WAYS = 2;
  localparam int SAW  = 6;
  localparam int CB   = 3;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  icache_valid_array_if #(.WAYS(WAYS), .SET_ADDR_WIDTH(SAW), .CHUNK_BITS(CB)) bus ();

  icache_valid_array #(.WAYS(WAYS), .SET_ADDR_WIDTH(SAW), .CHUNK_BITS(CB)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic       rd_en;
    logic [5:0] rd_addr;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [1:0] mask;
    logic       value;
    logic [1:0] exp_rd;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.rd_en       = 1'b0;
    bus.rd_addr     = '0;
    bus.wr_en       = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_way_mask = '0;
    bus.wr_value    = 1'b0;
    bus.inv_start   = 1'b0;
    bus.inv_all     = 1'b0;
    bus.inv_base    = '0;
    bus.inv_len     = '0;
  endtask

  // Inputs change 1 time unit after each rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fill_all();
    for (int s = 0; s < 64; s++) begin
      bus.wr_en       = 1'b1;
      bus.wr_addr     = 6'(s);
      bus.wr_way_mask = 2'b11;
      bus.wr_value    = 1'b1;
      tick();
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic check_sets(input string name, input logic [63:0] cleared);
    for (int s = 0; s < 64; s++) begin
      bus.rd_en   = 1'b1;
      bus.rd_addr = 6'(s);
      tick();
      check($sformatf("%s set%0d", name, s), 32'(bus.rd_data), cleared[s] ? 32'h0 : 32'h3);
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic read_set(input string name, input int s, input logic [1:0] exp);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 6'(s);
    tick();
    bus.rd_en = 1'b0;
    check(name, 32'(bus.rd_data), 32'(exp));
  endtask

  // Start a sweep and follow it to IDLE, counting busy cycles and done pulses.
  task automatic run_sweep(input string name, input logic all, input logic [2:0] base,
                           input logic [2:0] len, input logic hold_start,
                           input logic wr_during, input int exp_busy);
    int   busy_cycles = 0;
    int   done_pulses = 0;
    logic last_done   = 1'b0;
    logic idle_seen   = 1'b0;
    bus.inv_start = 1'b1;
    bus.inv_all   = all;
    bus.inv_base  = base;
    bus.inv_len   = len;
    tick();
    if (hold_start) begin
      bus.inv_all  = 1'b1;
      bus.inv_base = 3'd0;
    end else begin
      bus.inv_start = 1'b0;
    end
    for (int c = 0; c < 40; c++) begin
      if (!bus.inv_busy) begin
        idle_seen = 1'b1;
        break;
      end
      busy_cycles++;
      if (bus.inv_done) done_pulses++;
      last_done = bus.inv_done;
      check($sformatf("%s wr_ready low while busy", name), 32'(bus.wr_ready), 32'h0);
      if (wr_during) begin
        bus.wr_en       = 1'b1;
        bus.wr_addr     = 6'd3;
        bus.wr_way_mask = 2'b11;
        bus.wr_value    = 1'b1;
      end
      tick();
    end
    idle_inputs();
    check($sformatf("%s terminates", name), 32'(idle_seen), 32'h1);
    check($sformatf("%s busy cycles", name), 32'(busy_cycles), 32'(exp_busy));
    check($sformatf("%s done pulses", name), 32'(done_pulses), 32'h1);
    check($sformatf("%s done on last busy cycle", name), 32'(last_done), 32'h1);
    check($sformatf("%s wr_ready after", name), 32'(bus.wr_ready), 32'h1);
  endtask

  vec_t vecs [12];

  initial begin
    // {rd_en, rd_addr, wr_en, wr_addr, mask, value, exp_rd}
    vecs[0]  = '{1'b1, 6'd5,  1'b1, 6'd5,  2'b10, 1'b1, 2'b00};
    vecs[1]  = '{1'b1, 6'd5,  1'b0, 6'd0,  2'b00, 1'b0, 2'b10};
    vecs[2]  = '{1'b1, 6'd5,  1'b1, 6'd5,  2'b01, 1'b1, 2'b10};
    vecs[3]  = '{1'b1, 6'd5,  1'b0, 6'd0,  2'b00, 1'b0, 2'b11};
    vecs[4]  = '{1'b0, 6'd5,  1'b1, 6'd5,  2'b10, 1'b0, 2'b11};
    vecs[5]  = '{1'b1, 6'd5,  1'b0, 6'd0,  2'b00, 1'b0, 2'b01};
    vecs[6]  = '{1'b1, 6'd0,  1'b1, 6'd63, 2'b11, 1'b1, 2'b00};
    vecs[7]  = '{1'b1, 6'd63, 1'b0, 6'd0,  2'b00, 1'b0, 2'b11};
    vecs[8]  = '{1'b1, 6'd63, 1'b1, 6'd63, 2'b00, 1'b0, 2'b11};
    vecs[9]  = '{1'b1, 6'd63, 1'b1, 6'd63, 2'b01, 1'b0, 2'b11};
    vecs[10] = '{1'b1, 6'd63, 1'b0, 6'd0,  2'b00, 1'b0, 2'b10};
    vecs[11] = '{1'b1, 6'd5,  1'b0, 6'd0,  2'b00, 1'b0, 2'b01};

    reset_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clock);
    #1;
    check("reset rd_data", 32'(bus.rd_data), 32'h0);
    check("reset inv_busy", 32'(bus.inv_busy), 32'h0);
    check("reset inv_done", 32'(bus.inv_done), 32'h0);
    check("reset wr_ready", 32'(bus.wr_ready), 32'h1);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      bus.rd_en       = vecs[i].rd_en;
      bus.rd_addr     = vecs[i].rd_addr;
      bus.wr_en       = vecs[i].wr_en;
      bus.wr_addr     = vecs[i].wr_addr;
      bus.wr_way_mask = vecs[i].mask;
      bus.wr_value    = vecs[i].value;
      tick();
      check($sformatf("vec%0d rd_data", i), 32'(bus.rd_data), 32'(vecs[i].exp_rd));
      check($sformatf("vec%0d inv_busy", i), 32'(bus.inv_busy), 32'h0);
    end
    idle_inputs();

    // Full sweep with writes hammering set 3 while busy.
    fill_all();
    run_sweep("all", 1'b1, 3'd5, 3'd2, 1'b0, 1'b1, 9);
    check_sets("all", {64{1'b1}});

    // Ranged sweep wrapping past the last chunk: chunks 6,7,0,1.
    fill_all();
    run_sweep("range", 1'b0, 3'd6, 3'd3, 1'b0, 1'b0, 5);
    check_sets("range", 64'hFFFF_0000_0000_FFFF);

    // inv_start held (with different controls) during the sweep is ignored.
    fill_all();
    run_sweep("hold", 1'b0, 3'd2, 3'd1, 1'b1, 1'b0, 3);
    check_sets("hold", 64'h0000_0000_FFFF_0000);

    // Write and start in the same IDLE cycle: the sweep then clears it if in range.
    bus.wr_en = 1'b1; bus.wr_addr = 6'd20; bus.wr_way_mask = 2'b11; bus.wr_value = 1'b1;
    run_sweep("wr+start in", 1'b0, 3'd2, 3'd0, 1'b0, 1'b0, 2);
    read_set("wr+start in range", 20, 2'b00);
    bus.wr_en = 1'b1; bus.wr_addr = 6'd30; bus.wr_way_mask = 2'b11; bus.wr_value = 1'b1;
    run_sweep("wr+start out", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 2);
    read_set("wr+start out of range", 30, 2'b11);

    // Reset during the 3rd SWEEP cycle aborts without a done pulse.
    fill_all();
    bus.inv_start = 1'b1;
    bus.inv_all   = 1'b1;
    tick();
    bus.inv_start = 1'b0;
    bus.rd_en     = 1'b1;
    bus.rd_addr   = 6'd63;
    tick();
    bus.rd_en = 1'b0;
    tick();
    check("abort read during sweep", 32'(bus.rd_data), 32'h3);
    check("abort busy before reset", 32'(bus.inv_busy), 32'h1);
    reset_n = 1'b0;
    #1;
    check("abort rd_data", 32'(bus.rd_data), 32'h0);
    check("abort inv_busy", 32'(bus.inv_busy), 32'h0);
    check("abort inv_done", 32'(bus.inv_done), 32'h0);
    check("abort wr_ready", 32'(bus.wr_ready), 32'h1);
    tick();
    reset_n = 1'b1;
    begin
      int done_seen = 0;
      int busy_seen = 0;
      for (int c = 0; c < 20; c++) begin
        tick();
        if (bus.inv_done) done_seen++;
        if (bus.inv_busy) busy_seen++;
      end
      check("abort no done after release", 32'(done_seen), 32'h0);
      check("abort no busy after release", 32'(busy_seen), 32'h0);
    end
    check_sets("abort", {64{1'b1}});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/icache_valid_array.md
ICACHE_VALID_ARRAY -- requirements
Module: icache_valid_array

Interface
REQ-001 Parameter WAYS, default 2: number of ways; one valid bit per way per set; legal 1..8.
REQ-002 Parameter SET_ADDR_WIDTH, default 6: sets = 2^SET_ADDR_WIDTH.
REQ-003 Parameter CHUNK_BITS, default 3: sets cleared per sweep cycle = 2^CHUNK_BITS; legal 0..SET_ADDR_WIDTH; CW = SET_ADDR_WIDTH-CHUNK_BITS, chunks = 2^CW.
REQ-004 clock  in  1  single clock; all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 rd_en  in  1  read request.
REQ-007 rd_addr  in  SET_ADDR_WIDTH  read set index.
REQ-008 rd_data  out  WAYS  registered valid bits of the set read.
REQ-009 wr_en  in  1  write request.
REQ-010 wr_addr  in  SET_ADDR_WIDTH  write set index.
REQ-011 wr_way_mask  in  WAYS  ways affected by write.
REQ-012 wr_value  in  1  value written to masked ways (1 = fill, 0 = single-line invalidate).
REQ-013 inv_start  in  1  start bulk invalidate.
REQ-014 inv_all  in  1  sweep every chunk; inv_base/inv_len ignored.
REQ-015 inv_base  in  CW  first chunk of ranged sweep.
REQ-016 inv_len  in  CW  ranged sweep covers inv_len+1 chunks.
REQ-017 inv_busy  out  1  sweep engine active (SWEEP or DONE).
REQ-018 inv_done  out  1  one-cycle pulse on sweep completion.
REQ-019 wr_ready  out  1  equals !inv_busy.

Function
REQ-020 Array SHALL be flop-based, WAYS x 2^SET_ADDR_WIDTH bits.
REQ-021 Read latency SHALL be 1 cycle: rd_en at edge N loads rd_data with array[rd_addr] as of before edge N; rd_data holds when rd_en low.
REQ-022 Read and write/clear to the same set in the same cycle SHALL return pre-update contents (read-before-write).
REQ-023 wr_en with wr_ready high SHALL set masked ways of wr_addr to wr_value; unmasked ways unchanged.
REQ-024 wr_en with wr_ready low SHALL be dropped with no array change; requester retries.
REQ-025 FSM states: IDLE, SWEEP, DONE; reset state IDLE.
REQ-026 IDLE: inv_start high -> SWEEP; latch ptr = inv_all ? 0 : inv_base, remain = inv_all ? chunks-1 : inv_len.
REQ-027 SWEEP: each cycle clear all ways of sets {ptr, 0..2^CHUNK_BITS-1}; ptr = ptr+1 modulo chunks (wraps past last chunk to 0); remain==0 -> DONE else remain-1.
REQ-028 DONE: inv_done high for exactly that cycle; next state IDLE.
REQ-029 Sweep duration SHALL be (inv_len+1) SWEEP cycles (chunks cycles for inv_all), inv_done one cycle after last clear.
REQ-030 inv_start outside IDLE SHALL be ignored.
REQ-031 wr_en and inv_start in the same IDLE cycle: write applied that edge, sweep begins next cycle and clears the written set if in range.
REQ-032 Reads SHALL be served in every state; read of a chunk being cleared that cycle returns old bits, later reads return 0.
REQ-033 inv_len = chunks-1 with any inv_base SHALL clear the whole array exactly once.
REQ-034 CHUNK_BITS = SET_ADDR_WIDTH: any sweep takes one SWEEP cycle.

Reset
REQ-035 reset_n low SHALL asynchronously clear all valid bits, rd_data = 0, FSM = IDLE, ptr/remain = 0, inv_busy = 0, inv_done = 0, wr_ready = 1.
REQ-036 reset_n asserted mid-sweep SHALL abort the sweep with no inv_done pulse; operation resumes on first edge after release.

Verification (defaults WAYS=2, SET_ADDR_WIDTH=6, CHUNK_BITS=3, chunks=8)
REQ-037 Write set 5 mask 2'b10 value 1, then read set 5 -> rd_data = 2'b10 one cycle after rd_en; same-cycle read+write to set 5 returns 2'b00.
REQ-038 Fill all 64 sets to 2'b11, inv_start inv_all=1 -> inv_busy for 9 cycles (8 SWEEP + DONE), inv_done pulse once, all reads 2'b00, wr_en during busy dropped.
REQ-039 Fill all, inv_base=6 inv_len=3 -> chunks 6,7,0,1 (sets 48-63, 0-15) read 0, sets 16-47 read 2'b11.
REQ-040 inv_start repeated during SWEEP -> ignored, single inv_done, duration unchanged.
REQ-041 Fill all, start inv_all, drop reset_n at 3rd SWEEP cycle -> immediately all outputs 0, wr_ready=1, no inv_done, all sets 2'b00.
